// File: rtl/snake_tick_pkg.sv
// Shared state encodings and period arithmetic for the snake move-tick controller.
package snake_tick_pkg;

  localparam int STATE_W = 2;

  localparam logic [STATE_W-1:0] ST_IDLE  = 2'd0;
  localparam logic [STATE_W-1:0] ST_LOAD  = 2'd1;
  localparam logic [STATE_W-1:0] ST_RUN   = 2'd2;
  localparam logic [STATE_W-1:0] ST_PAUSE = 2'd3;

  // Faster levels shorten the period linearly until it bottoms out at the floor.
  function automatic logic [31:0] calc_period(input logic [2:0]  level,
                                              input logic [31:0] base,
                                              input logic [31:0] step,
                                              input logic [31:0] floor);
    logic [31:0] dec;
    dec = {29'd0, level} * step;
    if (dec > base - floor) return floor;
    return base - dec;
  endfunction

endpackage

// File: rtl/snake_tick_ctrl_cnt.sv
// 32-bit reversible counter with synchronous load and zero-reached flag.
module counter_32_rev (
  input  logic        clk,
  input  logic        s,
  input  logic        load,
  input  logic [31:0] p_data,
  output logic [31:0] cnt,
  output logic        rc
);

  // NOTE: no reset on this datapath register; the owner loads it every
  // non-counting cycle, so a reset would only add routing.
  always_ff @(posedge clk) begin
    if (load)   cnt <= p_data;
    else if (s) cnt <= cnt - 32'd1;
    else        cnt <= cnt + 32'd1;
  end

  assign rc = s && (cnt == 32'd0);

endmodule

// File: rtl/snake_tick_ctrl.sv
// Programmable move-tick timer: sequences one down-counter through
// IDLE/LOAD/RUN/PAUSE and emits a one-cycle tick at each period expiry.
module snake_tick_ctrl
  import snake_tick_pkg::*;
#(
  parameter logic [31:0] BASE_PERIOD = 32'd25_000_000,
  parameter logic [31:0] STEP_PERIOD = 32'd2_500_000,
  parameter logic [31:0] MIN_PERIOD  = 32'd2_500_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        stop,
  input  logic        pause_tog,
  input  logic [2:0]  level,
  output logic        tick,
  output logic        busy,
  output logic        paused,
  output logic [31:0] remain
);

  logic [STATE_W-1:0] state;
  logic [STATE_W-1:0] state_nxt;
  logic               cnt_load;
  logic [31:0]        cnt_data;
  logic [31:0]        cnt;
  logic               rc;
  logic [31:0]        reload_val;

  assign reload_val = calc_period(level, BASE_PERIOD, STEP_PERIOD, MIN_PERIOD) - 32'd1;

  // NOTE: every output of this block is given a default first, so no path
  // through the case leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    cnt_load  = 1'b1;
    cnt_data  = '0;
    case (state)
      ST_IDLE: begin
        if (start) state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        cnt_data  = reload_val;
        state_nxt = stop ? ST_IDLE : ST_RUN;
      end
      ST_RUN: begin
        // Expiry reloads regardless of any control pulse in the same cycle.
        cnt_load = rc;
        cnt_data = reload_val;
        if (stop)           state_nxt = ST_IDLE;
        else if (start)     state_nxt = ST_LOAD;
        else if (pause_tog) state_nxt = ST_PAUSE;
      end
      ST_PAUSE: begin
        cnt_data = cnt;
        if (stop)           state_nxt = ST_IDLE;
        else if (start)     state_nxt = ST_LOAD;
        else if (pause_tog) state_nxt = ST_RUN;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignment so every flop
  // samples the pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  counter_32_rev u_cnt (
    .clk    (clk),
    .s      (1'b1),
    .load   (cnt_load),
    .p_data (cnt_data),
    .cnt    (cnt),
    .rc     (rc)
  );

  assign tick   = (state == ST_RUN) && rc;
  assign busy   = (state != ST_IDLE);
  assign paused = (state == ST_PAUSE);
  assign remain = ((state == ST_RUN) || (state == ST_PAUSE)) ? cnt : '0;

endmodule

// File: tb/tb_snake_tick_ctrl.sv
// Scoreboard bench: directed stimulus pushes expected tick cycles, a negedge
// monitor pops and compares each tick the controller emits.
module tb_snake_tick_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        pause_tog = 1'b0;
  logic [2:0]  level = 3'd0;
  logic        tick;
  logic        busy;
  logic        paused;
  logic [31:0] remain;

  int cyc = 0;
  int checks = 0;
  int failures = 0;
  int exp_q[$];

  snake_tick_ctrl #(
    .BASE_PERIOD (32'd10),
    .STEP_PERIOD (32'd2),
    .MIN_PERIOD  (32'd4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .stop      (stop),
    .pause_tog (pause_tog),
    .level     (level),
    .tick      (tick),
    .busy      (busy),
    .paused    (paused),
    .remain    (remain)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Tick monitor: every tick must match the oldest expected tick cycle.
  always @(negedge clk) begin
    if (rst_n && tick === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_tick actual=tick at cycle %0d expected=no tick", cyc);
      end else begin
        int e;
        e = exp_q.pop_front();
        check("tick_cycle", cyc, e);
      end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) step();
  endtask

  task automatic pulse(input logic st, input logic sp, input logic pt);
    start = st; stop = sp; pause_tog = pt;
    step();
    start = 1'b0; stop = 1'b0; pause_tog = 1'b0;
  endtask

  task automatic stop_and_check(input string tag);
    pulse(1'b0, 1'b1, 1'b0);
    check({tag, "_busy"},   busy,   1'b0);
    check({tag, "_paused"}, paused, 1'b0);
    check({tag, "_remain"}, remain, 32'd0);
    check({tag, "_pending_ticks"}, exp_q.size(), 32'd0);
    exp_q.delete();
  endtask

  task automatic run_periods(input logic [2:0] lvl, input int p, input int n, input string tag);
    int t0;
    level = lvl;
    t0 = cyc;
    for (int k = 0; k < n; k++) exp_q.push_back(t0 + p + 1 + k * p);
    pulse(1'b1, 1'b0, 1'b0);
    step();
    check({tag, "_first_remain"}, remain, p - 1);
    check({tag, "_busy"}, busy, 1'b1);
    wait_until(t0 + p + 1 + (n - 1) * p + 1);
    stop_and_check(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t0;
    int r;

    // Reset state, both during and after reset.
    step(2);
    check("rst_busy",   busy,   1'b0);
    check("rst_paused", paused, 1'b0);
    check("rst_remain", remain, 32'd0);
    check("rst_tick",   tick,   1'b0);
    #3 rst_n = 1'b1;
    step(3);
    check("post_rst_busy",   busy,   1'b0);
    check("post_rst_remain", remain, 32'd0);

    // Level 0: first tick 11 cycles after start, then every 10; remain 9..0.
    level = 3'd0;
    t0 = cyc;
    exp_q.push_back(t0 + 11);
    exp_q.push_back(t0 + 21);
    exp_q.push_back(t0 + 31);
    pulse(1'b1, 1'b0, 1'b0);
    check("load_busy",   busy,   1'b1);
    check("load_remain", remain, 32'd0);
    check("load_paused", paused, 1'b0);
    step();
    for (int i = 0; i < 10; i++) begin
      check("count_down", remain, 9 - i);
      step();
    end
    check("reload_remain", remain, 32'd9);
    wait_until(t0 + 32);
    stop_and_check("lvl0");

    // Period per level, including the floor.
    run_periods(3'd2, 6, 3, "lvl2");
    run_periods(3'd7, 4, 3, "lvl7");
    run_periods(3'd5, 4, 2, "lvl5");

    // Pause freezes remain, resume continues from the frozen value.
    level = 3'd0;
    t0 = cyc;
    pulse(1'b1, 1'b0, 1'b0);
    wait_until(t0 + 5);
    check("pre_pause_remain", remain, 32'd6);
    pulse(1'b0, 1'b0, 1'b1);
    check("pause_paused", paused, 1'b1);
    check("pause_remain", remain, 32'd5);
    step(20);
    check("pause_hold_remain", remain, 32'd5);
    check("pause_hold_paused", paused, 1'b1);
    r = cyc;
    exp_q.push_back(r + 6);
    exp_q.push_back(r + 16);
    pulse(1'b0, 1'b0, 1'b1);
    check("resume_paused", paused, 1'b0);
    check("resume_remain", remain, 32'd5);
    wait_until(r + 17);
    stop_and_check("pause");

    // Level change mid-period applies only at the next reload.
    level = 3'd0;
    t0 = cyc;
    exp_q.push_back(t0 + 11);
    exp_q.push_back(t0 + 15);
    exp_q.push_back(t0 + 19);
    pulse(1'b1, 1'b0, 1'b0);
    wait_until(t0 + 5);
    level = 3'd3;
    wait_until(t0 + 12);
    check("midlevel_reload_remain", remain, 32'd3);
    wait_until(t0 + 20);
    stop_and_check("midlevel");

    // Expiry together with pause_tog: tick, then PAUSE frozen at P-1.
    level = 3'd0;
    t0 = cyc;
    exp_q.push_back(t0 + 11);
    pulse(1'b1, 1'b0, 1'b0);
    wait_until(t0 + 11);
    pulse(1'b0, 1'b0, 1'b1);
    check("rc_pause_paused", paused, 1'b1);
    check("rc_pause_remain", remain, 32'd9);
    step(5);
    check("rc_pause_hold", remain, 32'd9);
    stop_and_check("rc_pause");

    // Expiry together with stop: tick still fires, then IDLE.
    level = 3'd7;
    t0 = cyc;
    exp_q.push_back(t0 + 5);
    pulse(1'b1, 1'b0, 1'b0);
    wait_until(t0 + 5);
    stop_and_check("rc_stop");

    // Priority: stop beats pause_tog, start beats pause_tog.
    level = 3'd0;
    t0 = cyc;
    pulse(1'b1, 1'b0, 1'b0);
    wait_until(t0 + 4);
    pulse(1'b0, 1'b1, 1'b1);
    check("stop_pt_busy",   busy,   1'b0);
    check("stop_pt_paused", paused, 1'b0);
    check("stop_pt_remain", remain, 32'd0);
    r = cyc;
    pulse(1'b1, 1'b0, 1'b1);
    check("start_pt_idle_busy",   busy,   1'b1);
    check("start_pt_idle_paused", paused, 1'b0);
    check("start_pt_idle_remain", remain, 32'd0);
    wait_until(r + 4);
    t0 = cyc;
    exp_q.push_back(t0 + 11);
    pulse(1'b1, 1'b0, 1'b1);
    check("start_pt_run_paused", paused, 1'b0);
    check("start_pt_run_remain", remain, 32'd0);
    wait_until(t0 + 12);
    check("start_pt_run_late_paused", paused, 1'b0);
    stop_and_check("prio");

    // Asynchronous reset mid-RUN clears outputs immediately.
    level = 3'd0;
    t0 = cyc;
    pulse(1'b1, 1'b0, 1'b0);
    wait_until(t0 + 6);
    check("pre_areset_busy", busy, 1'b1);
    #3 rst_n = 1'b0;
    #1;
    check("areset_tick",   tick,   1'b0);
    check("areset_busy",   busy,   1'b0);
    check("areset_paused", paused, 1'b0);
    check("areset_remain", remain, 32'd0);
    step(2);
    #3 rst_n = 1'b1;
    step(30);
    check("post_areset_busy",   busy,   1'b0);
    check("post_areset_remain", remain, 32'd0);
    check("post_areset_pending", exp_q.size(), 32'd0);
    run_periods(3'd0, 10, 1, "after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
